// File: rtl/minmax_avg_param.sv
// rtl/minmax_avg_param.sv - frame min/max tracker with midpoint (min+max)/2 result
// Collects DEPTH valid samples per frame, then reports min, max and their average for one cycle.
module minmax_avg_param #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 8,
    parameter int SIGNED_MODE = 0,
    parameter int ROUND       = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] W,
    output logic [DATA_W-1:0] min_out,
    output logic [DATA_W-1:0] max_out
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CALC    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] run_min;
    logic [DATA_W-1:0] run_max;
    logic [DATA_W:0]   min_ext;
    logic [DATA_W:0]   max_ext;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] avg;
    logic              smaller;
    logic              larger;

    always_comb begin
        smaller = 1'b0;
        larger  = 1'b0;
        min_ext = {1'b0, run_min};
        max_ext = {1'b0, run_max};
        if (SIGNED_MODE != 0) begin
            smaller = $signed(data) < $signed(run_min);
            larger  = $signed(data) > $signed(run_max);
            min_ext = {run_min[DATA_W-1], run_min};
            max_ext = {run_max[DATA_W-1], run_max};
        end else begin
            smaller = data < run_min;
            larger  = data > run_max;
        end
        sum = min_ext + max_ext + (DATA_W+1)'(ROUND != 0 ? 1 : 0);
        // Dropping bit 0 of the widened sum is the shift; the kept bits match for signed and unsigned.
        avg = sum[DATA_W:1];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            run_min <= '0;
            run_max <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            W       <= '0;
            min_out <= '0;
            max_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= COLLECT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (data_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == '0) begin
                            run_min <= data;
                            run_max <= data;
                        end else begin
                            if (smaller) run_min <= data;
                            if (larger)  run_max <= data;
                        end
                        if (cnt == CNT_W'(DEPTH - 1)) begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        W       <= avg;
                        min_out <= run_min;
                        max_out <= run_max;
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= COLLECT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minmax_avg_param.sv
// tb/tb_minmax_avg_param.sv - self-checking bench for minmax_avg_param across parameter sets
// Four 8-bit instances (unsigned/signed x floor/round) share one stream; a 12-bit DEPTH=3 instance runs alone.
module tb_minmax_avg_param;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic       start8, abort8, dv8;
    logic [7:0] data8;
    logic       busy_o [4];
    logic       done_o [4];
    logic [7:0] w_o    [4];
    logic [7:0] min_o  [4];
    logic [7:0] max_o  [4];

    logic        start12, abort12, dv12;
    logic [11:0] data12;
    logic        busy12, done12;
    logic [11:0] w12, min12, max12;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] frame   [8];
    logic [7:0] exp_w   [4];
    logic [7:0] exp_min [4];
    logic [7:0] exp_max [4];

    minmax_avg_param #(.DATA_W(8), .DEPTH(8), .SIGNED_MODE(0), .ROUND(0)) u_u_fl (
        .clock(clock), .reset(reset), .start(start8), .abort(abort8), .data_valid(dv8), .data(data8),
        .busy(busy_o[0]), .done(done_o[0]), .W(w_o[0]), .min_out(min_o[0]), .max_out(max_o[0]));
    minmax_avg_param #(.DATA_W(8), .DEPTH(8), .SIGNED_MODE(0), .ROUND(1)) u_u_rn (
        .clock(clock), .reset(reset), .start(start8), .abort(abort8), .data_valid(dv8), .data(data8),
        .busy(busy_o[1]), .done(done_o[1]), .W(w_o[1]), .min_out(min_o[1]), .max_out(max_o[1]));
    minmax_avg_param #(.DATA_W(8), .DEPTH(8), .SIGNED_MODE(1), .ROUND(0)) u_s_fl (
        .clock(clock), .reset(reset), .start(start8), .abort(abort8), .data_valid(dv8), .data(data8),
        .busy(busy_o[2]), .done(done_o[2]), .W(w_o[2]), .min_out(min_o[2]), .max_out(max_o[2]));
    minmax_avg_param #(.DATA_W(8), .DEPTH(8), .SIGNED_MODE(1), .ROUND(1)) u_s_rn (
        .clock(clock), .reset(reset), .start(start8), .abort(abort8), .data_valid(dv8), .data(data8),
        .busy(busy_o[3]), .done(done_o[3]), .W(w_o[3]), .min_out(min_o[3]), .max_out(max_o[3]));
    minmax_avg_param #(.DATA_W(12), .DEPTH(3), .SIGNED_MODE(0), .ROUND(0)) u_w12 (
        .clock(clock), .reset(reset), .start(start12), .abort(abort12), .data_valid(dv12), .data(data12),
        .busy(busy12), .done(done12), .W(w12), .min_out(min12), .max_out(max12));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference: min/max under the instance's number interpretation, then floor((min+max+r)/2).
    task automatic model8();
        for (int k = 0; k < 4; k++) begin
            int mn, mx, v, s;
            mn = 0; mx = 0;
            for (int i = 0; i < 8; i++) begin
                v = (k >= 2) ? int'($signed(frame[i])) : int'(frame[i]);
                if (i == 0 || v < mn) mn = v;
                if (i == 0 || v > mx) mx = v;
            end
            s = (mn + mx + (k % 2)) >>> 1;
            exp_w[k]   = s[7:0];
            exp_min[k] = mn[7:0];
            exp_max[k] = mx[7:0];
        end
    endtask

    task automatic run_frame8(input int max_gap, input bit poke_start);
        int gap;
        start8 = 1'b1; dv8 = 1'b1; data8 = 8'($urandom);
        step();
        start8 = 1'b0; dv8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                dv8 = 1'b0; data8 = 8'($urandom);
                start8 = poke_start ? 1'($urandom) : 1'b0;
                step();
            end
            start8 = poke_start ? 1'b1 : 1'b0;
            dv8 = 1'b1; data8 = frame[i];
            step();
        end
        dv8 = 1'b0; start8 = 1'b0;
        model8();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (done_o[k] !== 1'b0 || busy_o[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL calc_cycle[%0d]: done=%b busy=%b, required done=0 busy=1", k, done_o[k], busy_o[k]);
            end
        end
        step();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (done_o[k] !== 1'b1 || w_o[k] !== exp_w[k] || min_o[k] !== exp_min[k] || max_o[k] !== exp_max[k]) begin
                n_fail++;
                $display("FAIL result[%0d]: done=%b W=%h min=%h max=%h, required done=1 W=%h min=%h max=%h",
                         k, done_o[k], w_o[k], min_o[k], max_o[k], exp_w[k], exp_min[k], exp_max[k]);
            end
        end
        step();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (done_o[k] !== 1'b0 || busy_o[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL done_width[%0d]: done=%b busy=%b, required 0 0", k, done_o[k], busy_o[k]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start8 = 0; abort8 = 0; dv8 = 0; data8 = '0;
        start12 = 0; abort12 = 0; dv12 = 0; data12 = '0;
        #2;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({busy_o[k], done_o[k], w_o[k], min_o[k], max_o[k]} !== 26'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: busy=%b done=%b W=%h min=%h max=%h, required all 0",
                         k, busy_o[k], done_o[k], w_o[k], min_o[k], max_o[k]);
            end
        end
        n_checks++;
        if ({busy12, done12, w12, min12, max12} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_state12: busy=%b done=%b W=%h min=%h max=%h, required all 0",
                     busy12, done12, w12, min12, max12);
        end
        step(); step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        frame = '{8'd10, 8'd200, 8'd3, 8'd77, 8'd45, 8'd255, 8'd0, 8'd128};
        run_frame8(0, 1'b0);
        n_checks++;
        if (w_o[0] !== 8'd127 || w_o[1] !== 8'd128 || min_o[0] !== 8'd0 || max_o[0] !== 8'd255) begin
            n_fail++;
            $display("FAIL basic_const: W0=%0d W1=%0d min=%0d max=%0d, required 127 128 0 255",
                     w_o[0], w_o[1], min_o[0], max_o[0]);
        end
    endtask

    task automatic test_signed();
        frame = '{8'h80, 8'd5, 8'h7F, 8'd0, 8'hFD, 8'd1, 8'd2, 8'd4};
        run_frame8(0, 1'b0);
        n_checks++;
        if (min_o[2] !== 8'h80 || max_o[2] !== 8'h7F || w_o[2] !== 8'hFF || w_o[3] !== 8'h00) begin
            n_fail++;
            $display("FAIL signed_const: min=%h max=%h W_fl=%h W_rn=%h, required 80 7f ff 00",
                     min_o[2], max_o[2], w_o[2], w_o[3]);
        end
    endtask

    task automatic test_all_same();
        for (int i = 0; i < 8; i++) frame[i] = 8'd9;
        run_frame8(0, 1'b0);
    endtask

    task automatic test_gaps();
        frame = '{8'd10, 8'd200, 8'd3, 8'd77, 8'd45, 8'd255, 8'd0, 8'd128};
        run_frame8(3, 1'b1);
    endtask

    task automatic test_abort();
        start8 = 1'b1; step(); start8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dv8 = 1'b1; data8 = 8'($urandom); step();
        end
        abort8 = 1'b1; dv8 = 1'b1; data8 = 8'($urandom);
        step();
        abort8 = 1'b0; dv8 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (busy_o[k] !== 1'b0 || done_o[k] !== 1'b0 || w_o[k] !== exp_w[k] ||
                    min_o[k] !== exp_min[k] || max_o[k] !== exp_max[k]) begin
                    n_fail++;
                    $display("FAIL abort_hold[%0d]: busy=%b done=%b W=%h min=%h max=%h, required 0 0 %h %h %h",
                             k, busy_o[k], done_o[k], w_o[k], min_o[k], max_o[k], exp_w[k], exp_min[k], exp_max[k]);
                end
            end
            step();
        end
        start8 = 1'b1; step(); start8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dv8 = 1'b1; data8 = 8'($urandom); step();
        end
        dv8 = 1'b0;
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({busy_o[k], done_o[k], w_o[k], min_o[k], max_o[k]} !== 26'd0) begin
                n_fail++;
                $display("FAIL midframe_reset[%0d]: busy=%b done=%b W=%h min=%h max=%h, required all 0",
                         k, busy_o[k], done_o[k], w_o[k], min_o[k], max_o[k]);
            end
        end
        step(); step();
        reset = 1'b1;
        step();
        for (int i = 0; i < 8; i++) frame[i] = 8'($urandom);
        run_frame8(2, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 8; i++) frame[i] = 8'($urandom);
            run_frame8(f % 3, f[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] f2 [3];
        int mn, mx, s;
        start12 = 1'b1; dv12 = 1'b0;
        step();
        dv12 = 1'b1; data12 = 12'd4095; step();
        data12 = 12'd1;    step();
        data12 = 12'd2048; step();
        dv12 = 1'b0;
        n_checks++;
        if (done12 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_early: done=%b, required 0", done12);
        end
        step();
        n_checks++;
        if (done12 !== 1'b1 || w12 !== 12'd2048 || min12 !== 12'd1 || max12 !== 12'd4095) begin
            n_fail++;
            $display("FAIL b2b_frame1: done=%b W=%0d min=%0d max=%0d, required 1 2048 1 4095",
                     done12, w12, min12, max12);
        end
        dv12 = 1'b1; data12 = 12'd0;
        step();
        n_checks++;
        if (busy12 !== 1'b1 || done12 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b done=%b, required 1 0", busy12, done12);
        end
        mn = 0; mx = 0;
        for (int i = 0; i < 3; i++) begin
            f2[i] = 12'($urandom_range(4095, 1));
            if (i == 0 || int'(f2[i]) < mn) mn = int'(f2[i]);
            if (i == 0 || int'(f2[i]) > mx) mx = int'(f2[i]);
            dv12 = 1'b1; data12 = f2[i]; step();
        end
        dv12 = 1'b0;
        s = (mn + mx) >>> 1;
        step();
        n_checks++;
        if (done12 !== 1'b1 || w12 !== s[11:0] || min12 !== mn[11:0] || max12 !== mx[11:0]) begin
            n_fail++;
            $display("FAIL b2b_frame2: done=%b W=%0d min=%0d max=%0d, required 1 %0d %0d %0d",
                     done12, w12, min12, max12, s, mn, mx);
        end
        start12 = 1'b0;
        step();
        n_checks++;
        if (busy12 !== 1'b0 || done12 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b done=%b, required 0 0", busy12, done12);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_all_same();
        test_gaps();
        test_abort();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
